// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared parameters, FSM state encoding and sizing helper for the 2x2 max-pooling stage.
package maxpool_2x2_stream_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_IMG_W  = 26;
  localparam int DEF_IMG_H  = 26;

  typedef enum logic [1:0] {
    ROW_A = 2'd0,
    ROW_B = 2'd1,
    SKIP  = 2'd2,
    DONE  = 2'd3
  } pool_state_t;

  // Index width that never collapses to zero bits for tiny dimensions.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_pool_line_buffer.sv
// Half-width line buffer holding the pairwise maxima of the even row; one write port,
// one combinational read port.
module pool_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 13,
  parameter int IW     = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Entry update; contents need no reset since every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_idx) < DEPTH)) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Combinational read, out-of-range indices return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < DEPTH) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pooling over a raster-ordered IMG_W x IMG_H map.
// Even rows fold into the line buffer; odd rows complete each window and emit it.
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  localparam int CW    = idx_width(IMG_W),
  localparam int RW    = idx_width(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     out_col,
  output logic [RW-1:0]     out_row,
  output logic              frame_done
);

  localparam int PW            = IMG_W / 2;
  localparam int PH            = IMG_H / 2;
  localparam int IW            = idx_width(PW);
  localparam int LAST_PAIR_COL = 2 * PW - 1;
  localparam int LAST_PAIR_ROW = 2 * PH - 1;
  localparam bit W_ODD         = (IMG_W % 2) != 0;
  localparam bit H_ODD         = (IMG_H % 2) != 0;

  // Signed maximum; the first operand wins a tie.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    if ($signed(b) > $signed(a)) begin
      return b;
    end else begin
      return a;
    end
  endfunction

  pool_state_t       state_r;
  logic [CW-1:0]     col_r;
  logic [RW-1:0]     row_r;
  logic [DATA_W-1:0] hold_r;

  logic              accept_s;
  logic              col_last_s;
  logic              row_last_s;
  logic              col_used_s;
  logic              pair_row_last_s;
  logic              frame_last_s;
  logic              row_a_s;
  logic              lbuf_we_s;
  logic [IW-1:0]     lbuf_idx_s;
  logic [DATA_W-1:0] lbuf_wd_s;
  logic [DATA_W-1:0] lbuf_rd_s;

  // Per-sample decode of position and line-buffer write.
  always_comb begin
    accept_s        = in_valid & ~clear;
    col_last_s      = (col_r == CW'(IMG_W - 1));
    row_last_s      = (row_r == RW'(IMG_H - 1));
    col_used_s      = ~(W_ODD & col_last_s);
    pair_row_last_s = (row_r == RW'(LAST_PAIR_ROW));
    frame_last_s    = pair_row_last_s & (col_r == CW'(LAST_PAIR_COL));
    lbuf_idx_s      = IW'(col_r >> 1);
    row_a_s         = (state_r == ROW_A) | (state_r == DONE);
    lbuf_we_s       = accept_s & row_a_s & col_r[0] & col_used_s;
    lbuf_wd_s       = smax(hold_r, in_data);
  end

  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (PW),
    .IW     (IW)
  ) u_lbuf (
    .clk     (clk),
    .wr_en   (lbuf_we_s),
    .wr_idx  (lbuf_idx_s),
    .wr_data (lbuf_wd_s),
    .rd_idx  (lbuf_idx_s),
    .rd_data (lbuf_rd_s)
  );

  // FSM, raster counters, hold register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ROW_A;
      col_r      <= '0;
      row_r      <= '0;
      hold_r     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_col    <= '0;
      out_row    <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      state_r    <= ROW_A;
      col_r      <= '0;
      row_r      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (accept_s) begin
        if (col_last_s) begin
          col_r <= '0;
          if (row_last_s) begin
            row_r <= '0;
          end else begin
            row_r <= row_r + RW'(1);
          end
        end else begin
          col_r <= col_r + CW'(1);
        end
        // DONE behaves as ROW_A at col 0: a sample there opens the next frame.
        case (state_r)
          ROW_A, DONE: begin
            if (!col_r[0] && col_used_s) begin
              hold_r <= in_data;
            end
            state_r <= col_last_s ? ROW_B : ROW_A;
          end
          ROW_B: begin
            if (!col_r[0] && col_used_s) begin
              hold_r <= smax(lbuf_rd_s, in_data);
            end
            if (col_r[0]) begin
              out_valid  <= 1'b1;
              out_data   <= smax(hold_r, in_data);
              out_col    <= col_r >> 1;
              out_row    <= row_r >> 1;
              frame_done <= frame_last_s;
            end
            if (col_last_s) begin
              if (pair_row_last_s) begin
                state_r <= H_ODD ? SKIP : DONE;
              end else begin
                state_r <= ROW_A;
              end
            end
          end
          SKIP: begin
            if (col_last_s) begin
              state_r <= DONE;
            end
          end
          default: begin
            state_r <= ROW_A;
          end
        endcase
      end else if (state_r == DONE) begin
        state_r <= ROW_A;
      end
    end
  end

endmodule
